reg_dump_reader: RTL and testbench

Sequential read-out engine for the 16 x 32-bit register file in the single-cycle core. It drives one register-file read port, walks a programmable index range, and streams each register value out over a valid/ready interface, tagged with its index and a last flag. It serves debug and self-check: benches and a future debug port dump architectural state without hand-sequencing `rd_reg_index` values.

---
 rtl/reg_dump_reader.sv | 82 ++++++++
 tb/tb_reg_dump_reader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// Register-file dump engine: walks an inclusive, wrapping index range on one
// read port and streams each value out with its index and a last flag.
module reg_dump_reader #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  first_idx,
  input  logic [IDX_W-1:0]  last_idx,
  output logic [IDX_W-1:0]  rd_reg_index,
  input  logic [DATA_W-1:0] rd_reg_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, ADDR, SEND, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] end_idx;

  // rd_reg_index doubles as the walk counter, so it is already registered
  // and stays stable through SEND.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      end_idx      <= '0;
      rd_reg_index <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_index    <= '0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rd_reg_index <= first_idx;
            end_idx      <= last_idx;
            busy         <= 1'b1;
            state        <= ADDR;
          end
        end
        ADDR: begin
          out_data  <= rd_reg_data;
          out_index <= rd_reg_index;
          out_last  <= (rd_reg_index == end_idx);
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              out_last <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              // Natural wrap at 2^IDX_W gives the through-zero ranges.
              rd_reg_index <= rd_reg_index + 1'b1;
              state        <= ADDR;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: a behavioural register file feeds the
// read port, and a scoreboard queue holds the words each dump should emit.
module tb_reg_dump_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  first_idx;
  logic [3:0]  last_idx;
  logic [3:0]  rd_reg_index;
  logic [31:0] rd_reg_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        done;

  reg_dump_reader #(.IDX_W(4), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .first_idx    (first_idx),
    .last_idx     (last_idx),
    .rd_reg_index (rd_reg_index),
    .rd_reg_data  (rd_reg_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_index    (out_index),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done)
  );

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] data;
    logic        last;
  } word_t;

  logic [31:0] regs [16];
  word_t       exp_q [$];
  int          nvec = 0;
  int          nerr = 0;
  int          done_cnt = 0;

  assign rd_reg_data = regs[rd_reg_index];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int i, input logic [31:0] d);
    if (i != 0) regs[i] = d;
  endtask

  task automatic push_range(input logic [3:0] f, input logic [3:0] l);
    logic [3:0] diff;
    logic [3:0] i;
    int n;
    diff = l - f;
    n = int'(diff) + 1;
    for (int k = 0; k < n; k++) begin
      i = f + 4'(k);
      exp_q.push_back('{idx: i, data: regs[i], last: (k == n - 1)});
    end
  endtask

  // Returns just after the edge that samples start.
  task automatic do_start(input logic [3:0] f, input logic [3:0] l);
    push_range(f, l);
    first_idx = f;
    last_idx  = l;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int start_cyc, input int exp_cyc);
    int cyc;
    bit seen;
    cyc  = start_cyc;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (done) seen = 1'b1;
      else begin
        @(posedge clk);
        #1 cyc++;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (exp_cyc > 0) check({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_busy_low_at_done"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1 check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
  endtask

  // Scoreboard: every accepted word must match the head of the queue.
  always @(negedge clk) begin
    if (rst) begin
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", 64'(out_index), 64'hFFFF);
        else begin
          word_t e;
          e = exp_q.pop_front();
          check("word_index", 64'(out_index), 64'(e.idx));
          check("word_data",  64'(out_data),  64'(e.data));
          check("word_last",  64'(out_last),  64'(e.last));
        end
      end
    end
  end

  initial begin
    int dc;
    for (int i = 0; i < 16; i++) regs[i] = (i == 0) ? 32'd0 : 32'hA000_0000 + 32'(i);
    rst = 1'b0;
    start = 1'b0;
    first_idx = '0;
    last_idx = '0;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_done",      64'(done),      64'd0);
    check("rst_rd_index",  64'(rd_reg_index), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Range 5..7
    wr(5, 32'd1234); wr(6, 32'd2431); wr(7, 32'd7);
    do_start(4'd5, 4'd7);
    check("t1_busy_at_E",     64'(busy), 64'd1);
    check("t1_rd_index_at_E", 64'(rd_reg_index), 64'd5);
    check("t1_valid_low_at_E", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("t1_valid_E1", 64'(out_valid), 64'd1);
    check("t1_index_E1", 64'(out_index), 64'd5);
    check("t1_data_E1",  64'(out_data),  64'd1234);
    wait_done("t1", 1, 6);
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

    // Wrap 14..1
    wr(14, 32'd14); wr(15, 32'd15); wr(1, 32'd11);
    do_start(4'd14, 4'd1);
    wait_done("t2", 0, 8);
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure on first word of 2..3
    out_ready = 1'b0;
    do_start(4'd2, 4'd3);
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      check("t3_hold_valid", 64'(out_valid), 64'd1);
      check("t3_hold_index", 64'(out_index), 64'd2);
      check("t3_hold_data",  64'(out_data),  64'(regs[2]));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_done("t3", 0, 0);
    check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // Single word with a start pulse while busy
    dc = done_cnt;
    do_start(4'd9, 4'd9);
    first_idx = 4'd0;
    last_idx  = 4'd15;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("t4", 0, 0);
    repeat (5) @(posedge clk);
    #1;
    check("t4_no_second_dump", 64'(out_valid), 64'd0);
    check("t4_idle_busy",      64'(busy), 64'd0);
    check("t4_done_count",     64'(done_cnt - dc), 64'd1);
    check("t4_queue_empty",    64'(exp_q.size()), 64'd0);

    // Full dump 4..3
    do_start(4'd4, 4'd3);
    wait_done("t5", 0, 32);
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset while word at index 1 of 0..15 is in SEND
    dc = done_cnt;
    do_start(4'd0, 4'd15);
    repeat (3) @(posedge clk);
    #1;
    check("t6_in_send_index", 64'(out_index), 64'd1);
    rst = 1'b0;
    #1;
    check("t6_rst_valid",    64'(out_valid), 64'd0);
    check("t6_rst_busy",     64'(busy),      64'd0);
    check("t6_rst_done",     64'(done),      64'd0);
    check("t6_rst_rd_index", 64'(rd_reg_index), 64'd0);
    check("t6_rst_data",     64'(out_data),  64'd0);
    check("t6_rst_index",    64'(out_index), 64'd0);
    check("t6_rst_last",     64'(out_last),  64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_no_done_after_abort", 64'(done_cnt - dc), 64'd0);
    do_start(4'd6, 4'd8);
    wait_done("t6", 0, 6);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t6_done_count",  64'(done_cnt - dc), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
